// File: rtl/pbch_re_demapper.sv
// SSB post-FFT demapper: splits the three PBCH symbols into DMRS and data RE streams
// using the cell DMRS shift, discarding SSS/guard subcarriers of symbol 2.
module pbch_re_demapper #(
    parameter int FP = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fft_valid,
    input  logic signed [FP/2-1:0] fft_in_i,
    input  logic signed [FP/2-1:0] fft_in_q,
    input  logic                   ssb_start,
    input  logic [1:0]             pci_mod4,
    output logic                   dmrs_push,
    output logic signed [FP/2-1:0] dmrs_i,
    output logic signed [FP/2-1:0] dmrs_q,
    output logic                   data_valid,
    output logic signed [FP/2-1:0] data_i,
    output logic signed [FP/2-1:0] data_q,
    output logic [1:0]             sym_idx,
    output logic                   done,
    output logic                   restart_err
);

    // Encodings double as the reported symbol index.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYM1 = 2'd1,
        SYM2 = 2'd2,
        SYM3 = 2'd3
    } state_t;

    localparam logic [7:0] K_LAST = 8'd239;

    state_t     state;
    logic [7:0] k;
    logic [1:0] v;

    logic       start_acc;
    logic       proc;
    state_t     cur_state;
    logic [7:0] cur_k;
    logic [1:0] cur_v;
    logic       in_region;
    logic       last_k;
    logic       hit_dmrs;
    logic       hit_data;

    // Symbol 2 carries PBCH only on the 48 subcarriers at each band edge.
    function automatic logic in_pbch_region(input state_t s, input logic [7:0] kk);
        if (s == SYM2) begin
            return (kk <= 8'd47) || (kk >= 8'd192);
        end
        return (s != IDLE);
    endfunction

    function automatic state_t next_sym(input state_t s);
        case (s)
            SYM1:    return SYM2;
            SYM2:    return SYM3;
            default: return IDLE;
        endcase
    endfunction

    // A start qualified by fft_valid overrides the running SSB, so the current
    // sample is classified as SYM1, k=0 with the freshly sampled shift.
    always_comb begin
        start_acc = fft_valid & ssb_start;
        proc      = fft_valid & (start_acc | (state != IDLE));
        cur_state = start_acc ? SYM1 : state;
        cur_k     = start_acc ? 8'd0 : k;
        cur_v     = start_acc ? pci_mod4 : v;
        in_region = in_pbch_region(cur_state, cur_k);
        last_k    = (cur_k == K_LAST);
        hit_dmrs  = proc & in_region & (cur_k[1:0] == cur_v);
        hit_data  = proc & in_region & (cur_k[1:0] != cur_v);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            k           <= 8'd0;
            v           <= 2'd0;
            dmrs_push   <= 1'b0;
            dmrs_i      <= '0;
            dmrs_q      <= '0;
            data_valid  <= 1'b0;
            data_i      <= '0;
            data_q      <= '0;
            sym_idx     <= 2'd0;
            done        <= 1'b0;
            restart_err <= 1'b0;
        end else begin
            dmrs_push   <= hit_dmrs;
            data_valid  <= hit_data;
            done        <= proc && (cur_state == SYM3) && last_k;
            restart_err <= start_acc && (state != IDLE);

            if (hit_dmrs) begin
                dmrs_i <= fft_in_i;
                dmrs_q <= fft_in_q;
            end
            if (hit_data) begin
                data_i <= fft_in_i;
                data_q <= fft_in_q;
            end

            // sym_idx follows the last processed RE and drops to 0 once idle.
            if (proc) begin
                sym_idx <= cur_state;
            end else if (state == IDLE) begin
                sym_idx <= 2'd0;
            end

            if (start_acc) begin
                v <= pci_mod4;
            end

            if (proc) begin
                if (last_k) begin
                    k     <= 8'd0;
                    state <= next_sym(cur_state);
                end else begin
                    k     <= cur_k + 8'd1;
                    state <= cur_state;
                end
            end
        end
    end

endmodule

// File: doc/pbch_re_demapper.md
# pbch_re_demapper

Post-FFT resource-element demapper for the SSB. Consumes the FFT output stream of the three PBCH-bearing SSB symbols (240 subcarriers each), separates PBCH data REs from PBCH DMRS REs using the cell's DMRS shift v = PCI mod 4, and discards SSS/guard REs. It sits directly upstream of the 144-entry I/Q buffer. The DMRS stream carries exactly 144 REs per SSB and drives the buffer's `push` / `bf_in_i` / `bf_in_q`. The data stream (432 REs) goes to the channel-estimation/equalisation stage.

## Interface
Parameters:
- FP, 10, total I+Q sample width; each component is FP/2 bits signed.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, asynchronous active-low reset.
- fft_valid, in, 1, qualifies fft_in_i/fft_in_q for one subcarrier.
- fft_in_i, in, FP/2 signed, FFT output, in-phase.
- fft_in_q, in, FP/2 signed, FFT output, quadrature.
- ssb_start, in, 1, sampled only with fft_valid=1; marks subcarrier k=0 of SSB symbol 1.
- pci_mod4, in, 2, DMRS shift v; sampled when a start is accepted.
- dmrs_push, out, 1, DMRS RE valid (to buffer push).
- dmrs_i, out, FP/2 signed, DMRS RE in-phase.
- dmrs_q, out, FP/2 signed, DMRS RE quadrature.
- data_valid, out, 1, PBCH data RE valid.
- data_i, out, FP/2 signed, data RE in-phase.
- data_q, out, FP/2 signed, data RE quadrature.
- sym_idx, out, 2, SSB symbol of the current output RE (1, 2, 3); 0 when idle.
- done, out, 1, one-cycle pulse coincident with the output of symbol 3, k=239.
- restart_err, out, 1, one-cycle pulse when ssb_start aborts an SSB in progress.

## Operation
- States: IDLE, SYM1, SYM2, SYM3.
- Subcarrier counter k: 8 bits, range 0..239. Advances only on fft_valid=1. At k=239 it wraps to 0 and moves to the next state: SYM1→SYM2→SYM3→IDLE.
- IDLE:
  - fft_valid=1 & ssb_start=1 → latch v = pci_mod4 and enter SYM1. That sample is processed as k=0 of SYM1.
  - Samples with fft_valid=1 & ssb_start=0 are dropped; no output.
- Classification of the current sample (k, state):
  - PBCH region: SYM1/SYM3 → all k. SYM2 → k ≤ 47 or k ≥ 192.
  - Inside the region: k[1:0] == v → DMRS RE; otherwise → data RE.
  - Outside the region (SYM2, 48 ≤ k ≤ 191) → discarded.
- Per-SSB totals:
  - DMRS: 60 + 24 + 60 = 144.
  - Data: 180 + 72 + 180 = 432.
- ssb_start=1 with fft_valid=1 while in SYM1/SYM2/SYM3:
  - Abort the current SSB and re-latch v.
  - Go to SYM1; the sample is processed as k=0.
  - Pulse restart_err.
  - No done is issued for the aborted SSB.
- ssb_start with fft_valid=0 is ignored in every state.
- v is held constant for a whole SSB; pci_mod4 changes mid-SSB have no effect.
- Sample values pass through unmodified; no arithmetic or width change.

## Timing
- All outputs are registered. Latency is 1 cycle: a sample accepted at edge n appears on the outputs after edge n+1.
- dmrs_push and data_valid are never high together. Both are low in any cycle following fft_valid=0, an IDLE-dropped sample, or a discarded RE.
- Data outputs hold their last value when the corresponding valid is low.
- No backpressure. The downstream buffer always has room, since 144 DMRS REs exactly fill one buffer per SSB.
- fft_valid gaps of any length are allowed; state, k and v are held.
- Back-to-back SSBs:
  - ssb_start may arrive in the cycle immediately after the sample at SYM3, k=239.
  - A start on the same sample as SYM3, k=239 is a restart: the sample is processed as SYM1, k=0, and restart_err pulses.
- Reset (asynchronous, any time, including mid-SSB):
  - State IDLE, k=0, v=0.
  - All outputs 0: dmrs_push, data_valid, dmrs_i/q, data_i/q, sym_idx, done, restart_err.
- After reset deassertion the block waits for a new ssb_start.

## Test plan
- v=0, one full SSB of 720 consecutive valid samples, value i=q=k mod 16 → 144 dmrs_push pulses and 432 data_valid pulses. SYM1 DMRS at k=0,4,…,236. SYM2 DMRS at k=0..44 and 192..236 step 4, nothing for k=48..191. done pulses once, with the SYM3, k=239 output.
- v=3, same stream with fft_valid low every other cycle → identical RE counts. DMRS at k=3,7,…,239. Outputs never coincide. Latency 1 cycle after each valid sample.
- Samples before ssb_start, and ssb_start with fft_valid=0 → no outputs, state stays IDLE, sym_idx=0.
- ssb_start re-asserted at SYM2, k=100 → restart_err pulse, sym_idx=1 on the next output. Full 144/432 counts follow, then exactly one done.
- rst asserted at SYM1, k=50 → all outputs 0 immediately. The next SSB after release produces exact 144/432 counts.
- Two back-to-back SSBs with v changed 0→2 between them → the second SSB's DMRS falls at k mod 4 = 2. done pulses twice, no restart_err.
